// File: rtl/fwd_hazard_unit_pkg.sv
// pipe_pkg: selector codes, hazard FSM encoding and default widths shared by the pipeline blocks.
package pipe_pkg;
  localparam int REG_W_D = 5;
  localparam int DATA_W_D = 32;
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB = 2'd2;
  localparam logic [1:0] FWD_SH = 2'd3;
  typedef enum logic {HZ_IDLE, HZ_STALL} hz_state_t;
endpackage

// File: rtl/fwd_hazard_unit_if.sv
// fwd_hazard_unit_if: pipeline-side operand, writeback and hazard signals seen by the forwarding unit.
interface fwd_hazard_unit_if
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int REG_W = REG_W_D,
  parameter int NUM_SRC = 2,
  parameter int CNT_W = 16
);
  logic flush;
  logic [NUM_SRC*REG_W-1:0] ex_src_reg;
  logic [NUM_SRC*DATA_W-1:0] ex_src_data;
  logic [REG_W-1:0] mem_reg;
  logic [DATA_W-1:0] mem_data;
  logic mem_regwr;
  logic mem_memread;
  logic [REG_W-1:0] wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic wb_regwr;
  logic [NUM_SRC*REG_W-1:0] id_src_reg;
  logic [NUM_SRC-1:0] id_src_used;
  logic [REG_W-1:0] ex_reg;
  logic ex_memread;
  logic [NUM_SRC*DATA_W-1:0] fwd_data;
  logic [NUM_SRC*2-1:0] fwd_sel;
  logic stall;
  logic [CNT_W-1:0] stall_count;
  modport master(
    output flush, ex_src_reg, ex_src_data, mem_reg, mem_data, mem_regwr, mem_memread,
           wb_reg, wb_data, wb_regwr, id_src_reg, id_src_used, ex_reg, ex_memread,
    input fwd_data, fwd_sel, stall, stall_count
  );
  modport slave(
    input flush, ex_src_reg, ex_src_data, mem_reg, mem_data, mem_regwr, mem_memread,
          wb_reg, wb_data, wb_regwr, id_src_reg, id_src_used, ex_reg, ex_memread,
    output fwd_data, fwd_sel, stall, stall_count
  );
endinterface

// File: rtl/fwd_hazard_unit_mux.sv
// fwd_mux: per-operand priority select MEM > WB > shadow > regfile; register 0 always reads the regfile.
module fwd_mux
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int REG_W = REG_W_D,
  parameter bit SHADOW_EN = 1'b1
) (
  input  logic [REG_W-1:0]  src_reg,
  input  logic [DATA_W-1:0] src_data,
  input  logic [REG_W-1:0]  mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_regwr,
  input  logic              mem_memread,
  input  logic [REG_W-1:0]  wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              wb_regwr,
  input  logic              sh_valid,
  input  logic [REG_W-1:0]  sh_reg,
  input  logic [DATA_W-1:0] sh_data,
  output logic [DATA_W-1:0] data,
  output logic [1:0]        sel
);
  always_comb begin
    sel = (src_reg == '0) ? FWD_RF :
          (mem_regwr && !mem_memread && mem_reg == src_reg) ? FWD_MEM :
          (wb_regwr && wb_reg == src_reg) ? FWD_WB :
          (SHADOW_EN && sh_valid && sh_reg == src_reg) ? FWD_SH : FWD_RF;
    data = (sel == FWD_MEM) ? mem_data :
           (sel == FWD_WB) ? wb_data :
           (sel == FWD_SH) ? sh_data : src_data;
  end
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX operand forwarding, one-cycle write-through shadow, load-use stall FSM and stall counter.
module fwd_hazard_unit
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int REG_W = REG_W_D,
  parameter int NUM_SRC = 2,
  parameter int LOAD_STALL = 1,
  parameter bit SHADOW_EN = 1'b1,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  fwd_hazard_unit_if.slave bus
);
  logic sh_valid;
  logic [REG_W-1:0] sh_reg;
  logic [DATA_W-1:0] sh_data;
  hz_state_t state;
  logic [3:0] rem;
  logic hit;
  logic haz;
  logic stall;
  logic [CNT_W-1:0] cnt;
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W), .SHADOW_EN(SHADOW_EN)) u_mux (
      .src_reg(bus.ex_src_reg[i*REG_W +: REG_W]),
      .src_data(bus.ex_src_data[i*DATA_W +: DATA_W]),
      .mem_reg(bus.mem_reg),
      .mem_data(bus.mem_data),
      .mem_regwr(bus.mem_regwr),
      .mem_memread(bus.mem_memread),
      .wb_reg(bus.wb_reg),
      .wb_data(bus.wb_data),
      .wb_regwr(bus.wb_regwr),
      .sh_valid(sh_valid),
      .sh_reg(sh_reg),
      .sh_data(sh_data),
      .data(bus.fwd_data[i*DATA_W +: DATA_W]),
      .sel(bus.fwd_sel[i*2 +: 2])
    );
  end
  always_comb begin
    hit = 1'b0;
    for (int j = 0; j < NUM_SRC; j++)
      hit = hit | (bus.id_src_used[j] && bus.id_src_reg[j*REG_W +: REG_W] == bus.ex_reg);
    haz = bus.ex_memread && bus.ex_reg != '0 && hit;
    stall = !reset && !bus.flush && (state == HZ_STALL || haz);
  end
  // The first stall cycle is the detection cycle itself; STALL covers the remaining LOAD_STALL-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= HZ_IDLE;
      rem <= '0;
      sh_valid <= 1'b0;
      cnt <= '0;
    end else begin
      sh_reg <= bus.wb_reg;
      sh_data <= bus.wb_data;
      sh_valid <= bus.wb_regwr && bus.wb_reg != '0;
      if (stall && cnt != '1) cnt <= cnt + 1'b1;
      if (bus.flush) begin
        state <= HZ_IDLE;
        rem <= '0;
      end else if (state == HZ_STALL) begin
        rem <= rem - 1'b1;
        if (rem == 4'd1) state <= HZ_IDLE;
      end else if (haz && LOAD_STALL > 1) begin
        state <= HZ_STALL;
        rem <= 4'(LOAD_STALL - 1);
      end
    end
  end
  assign bus.stall = stall;
  assign bus.stall_count = cnt;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed vectors with a queued scoreboard drained by a negedge monitor.
module tb_fwd_hazard_unit;
  localparam int K_D0 = 0, K_D1 = 1, K_SEL = 2, K_ST = 3, K_CNT = 4;
  typedef struct {
    string name;
    int dut;
    int kind;
    logic [31:0] val;
  } exp_t;
  exp_t q[$];
  int total = 0;
  int bad = 0;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;
  fwd_hazard_unit_if #(.CNT_W(16)) ba ();
  fwd_hazard_unit_if #(.CNT_W(4)) bb ();
  fwd_hazard_unit #(.LOAD_STALL(1), .CNT_W(16)) da (.clk(clk), .reset(rst_a), .bus(ba));
  fwd_hazard_unit #(.LOAD_STALL(3), .CNT_W(4)) db (.clk(clk), .reset(rst_b), .bus(bb));
  assign bb.flush = ba.flush;
  assign bb.ex_src_reg = ba.ex_src_reg;
  assign bb.ex_src_data = ba.ex_src_data;
  assign bb.mem_reg = ba.mem_reg;
  assign bb.mem_data = ba.mem_data;
  assign bb.mem_regwr = ba.mem_regwr;
  assign bb.mem_memread = ba.mem_memread;
  assign bb.wb_reg = ba.wb_reg;
  assign bb.wb_data = ba.wb_data;
  assign bb.wb_regwr = ba.wb_regwr;
  assign bb.id_src_reg = ba.id_src_reg;
  assign bb.id_src_used = ba.id_src_used;
  assign bb.ex_reg = ba.ex_reg;
  assign bb.ex_memread = ba.ex_memread;
  function automatic logic [31:0] act(int d, int k);
    if (d == 0)
      return k == K_D0 ? ba.fwd_data[31:0] : k == K_D1 ? ba.fwd_data[63:32] :
             k == K_SEL ? 32'(ba.fwd_sel) : k == K_ST ? 32'(ba.stall) : 32'(ba.stall_count);
    return k == K_D0 ? bb.fwd_data[31:0] : k == K_D1 ? bb.fwd_data[63:32] :
           k == K_SEL ? 32'(bb.fwd_sel) : k == K_ST ? 32'(bb.stall) : 32'(bb.stall_count);
  endfunction
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] a;
      e = q.pop_front();
      a = act(e.dut, e.kind);
      total++;
      if (a !== e.val) begin
        bad++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, a, e.val);
      end
    end
  end
  task automatic chk(string name, int dut, int kind, logic [31:0] val);
    exp_t e;
    e.name = name;
    e.dut = dut;
    e.kind = kind;
    e.val = val;
    q.push_back(e);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_haz(bit on);
    ba.ex_memread = on;
    ba.ex_reg = on ? 5'd3 : 5'd0;
    ba.id_src_reg = on ? 10'(3 << 5) : 10'd0;
    ba.id_src_used = on ? 2'b10 : 2'b00;
  endtask
  initial begin
    ba.flush = 0; ba.ex_src_reg = 0; ba.ex_src_data = 0;
    ba.mem_reg = 0; ba.mem_data = 0; ba.mem_regwr = 0; ba.mem_memread = 0;
    ba.wb_reg = 0; ba.wb_data = 0; ba.wb_regwr = 0;
    ba.id_src_reg = 0; ba.id_src_used = 0; ba.ex_reg = 0; ba.ex_memread = 0;
    rst_a = 1; rst_b = 1;
    tick();
    set_haz(1);
    chk("rst_stall_a", 0, K_ST, 0);
    chk("rst_stall_b", 1, K_ST, 0);
    tick();
    set_haz(0);
    chk("rst_cnt_a", 0, K_CNT, 0);
    chk("rst_cnt_b", 1, K_CNT, 0);
    tick();
    rst_a = 0;
    ba.ex_src_reg = 10'd5; ba.ex_src_data = 64'h0000_0000_0000_0F0F;
    ba.mem_reg = 5; ba.mem_data = 32'hAAAA0001; ba.mem_regwr = 1;
    ba.wb_reg = 5; ba.wb_data = 32'hBBBB0002; ba.wb_regwr = 1;
    chk("prio_mem_data", 0, K_D0, 32'hAAAA0001);
    chk("prio_mem_sel", 0, K_SEL, 4'b0001);
    chk("prio_port1_rf", 0, K_D1, 0);
    tick();
    ba.mem_regwr = 0;
    chk("prio_wb_data", 0, K_D0, 32'hBBBB0002);
    chk("prio_wb_sel", 0, K_SEL, 4'b0010);
    tick();
    ba.mem_regwr = 1; ba.mem_memread = 1;
    chk("load_nofwd_data", 0, K_D0, 32'hBBBB0002);
    chk("load_nofwd_sel", 0, K_SEL, 4'b0010);
    tick();
    ba.mem_memread = 0; ba.ex_src_reg = 0; ba.mem_reg = 0;
    ba.wb_reg = 0; ba.wb_data = 32'h55; ba.ex_src_data = 64'h0000_0000_0000_0011;
    chk("r0_data1", 0, K_D1, 0);
    chk("r0_data0", 0, K_D0, 32'h11);
    chk("r0_sel", 0, K_SEL, 0);
    tick();
    ba.mem_regwr = 0; ba.wb_reg = 7; ba.wb_data = 32'h12345678; ba.wb_regwr = 1;
    tick();
    ba.wb_regwr = 0; ba.wb_reg = 0; ba.ex_src_reg = 10'd7; ba.ex_src_data = 64'h0000_0000_0000_DEAD;
    chk("shadow_data", 0, K_D0, 32'h12345678);
    chk("shadow_sel", 0, K_SEL, 4'b0011);
    tick();
    chk("shadow_gone_data", 0, K_D0, 32'hDEAD);
    chk("shadow_gone_sel", 0, K_SEL, 0);
    chk("lu1_cnt_pre", 0, K_CNT, 0);
    set_haz(1);
    chk("lu1_stall", 0, K_ST, 1);
    tick();
    set_haz(0);
    chk("lu1_stall_end", 0, K_ST, 0);
    chk("lu1_cnt", 0, K_CNT, 1);
    tick();
    set_haz(1); ba.id_src_used = 0;
    chk("lu1_unused", 0, K_ST, 0);
    tick();
    set_haz(1); ba.ex_reg = 0; ba.id_src_reg = 0; ba.id_src_used = 2'b11;
    chk("lu1_r0", 0, K_ST, 0);
    tick();
    set_haz(0);
    chk("lu1_cnt_hold", 0, K_CNT, 1);
    rst_b = 0;
    tick();
    chk("lu3_cnt_pre", 1, K_CNT, 0);
    set_haz(1);
    chk("lu3_stall0", 1, K_ST, 1);
    tick();
    set_haz(0);
    chk("lu3_stall1", 1, K_ST, 1);
    tick();
    chk("lu3_stall2", 1, K_ST, 1);
    tick();
    chk("lu3_stall_end", 1, K_ST, 0);
    chk("lu3_cnt", 1, K_CNT, 3);
    tick();
    set_haz(1);
    chk("fl_stall0", 1, K_ST, 1);
    tick();
    set_haz(0); ba.flush = 1;
    chk("fl_stall_flush", 1, K_ST, 0);
    tick();
    ba.flush = 0;
    chk("fl_idle", 1, K_ST, 0);
    chk("fl_cnt", 1, K_CNT, 4);
    tick();
    set_haz(1);
    repeat (19) tick();
    chk("sat_cnt", 1, K_CNT, 15);
    chk("sat_stall", 1, K_ST, 1);
    tick();
    rst_b = 1; set_haz(0);
    ba.wb_reg = 9; ba.wb_data = 32'h99; ba.wb_regwr = 1;
    chk("midrst_stall", 1, K_ST, 0);
    tick();
    rst_b = 0; ba.wb_regwr = 0; ba.wb_reg = 0;
    ba.ex_src_reg = 10'd9; ba.ex_src_data = 64'h0000_0000_0000_0077;
    chk("postrst_cnt", 1, K_CNT, 0);
    chk("postrst_stall", 1, K_ST, 0);
    chk("postrst_nosh_data", 1, K_D0, 32'h77);
    chk("postrst_nosh_sel", 1, K_SEL, 0);
    tick();
    chk("postrst_cnt_hold", 1, K_CNT, 0);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and load-use hazard unit for the 5-stage pipeline; sits beside the EX stage.
- Forwards for NUM_SRC operand ports with priority MEM > WB > write-through shadow > register-file data. Never forwards register 0.
- Holds a one-entry write-through shadow covering the register-file write/read collision.
- Runs a load-use stall FSM with a configurable stall length.
- Keeps a saturating stall counter for performance tracking.

Parameters:
- DATA_W, 32, operand/data width.
- REG_W, 5, register-address width.
- NUM_SRC, 2, number of EX operand ports forwarded.
- LOAD_STALL, 1, stall cycles per load-use hazard; legal range 1..15.
- SHADOW_EN, 1, 1 = write-through shadow present; 0 = shadow logic removed and never selected.
- CNT_W, 16, stall-counter width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush; aborts any stall in progress.
- ex_src_reg  in  NUM_SRC*REG_W  EX operand register numbers; port i occupies slice [i*REG_W +: REG_W].
- ex_src_data  in  NUM_SRC*DATA_W  EX operand values read from the register file.
- mem_reg  in  REG_W  MEM-stage destination register.
- mem_data  in  DATA_W  MEM-stage ALU result.
- mem_regwr  in  1  MEM-stage instruction writes a register.
- mem_memread  in  1  MEM-stage instruction is a load (its data is not yet available).
- wb_reg  in  REG_W  WB-stage destination register.
- wb_data  in  DATA_W  WB-stage write data.
- wb_regwr  in  1  WB-stage instruction writes a register.
- id_src_reg  in  NUM_SRC*REG_W  ID-stage source register numbers.
- id_src_used  in  NUM_SRC  ID-stage source i is actually read.
- ex_reg  in  REG_W  EX-stage destination register.
- ex_memread  in  1  EX-stage instruction is a load.
- fwd_data  out  NUM_SRC*DATA_W  forwarded operand values.
- fwd_sel  out  NUM_SRC*2  source selected per port: 0 = regfile, 1 = MEM, 2 = WB, 3 = shadow.
- stall  out  1  freeze PC and IF/ID; insert a bubble into EX.
- stall_count  out  CNT_W  number of stall cycles asserted; saturating.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Forwarding is combinational and evaluated independently for each port i, with s = ex_src_reg[i]:
  - s == 0: select regfile (sel 0).
  - else if mem_regwr && !mem_memread && mem_reg == s: select MEM (sel 1).
  - else if wb_regwr && wb_reg == s: select WB (sel 2).
  - else if SHADOW_EN && sh_valid && sh_reg == s: select shadow (sel 3).
  - otherwise: select regfile (sel 0).
- A higher-priority candidate whose write-enable is low never masks a lower one; evaluation falls through to the next candidate.
- A MEM match on a load (mem_memread = 1) is not forwarded. The stall FSM guarantees this case never reaches the consumer.
- Shadow register:
  - Every cycle it captures sh_reg <= wb_reg, sh_data <= wb_data, sh_valid <= wb_regwr && (wb_reg != 0).
  - It therefore covers exactly one cycle after the WB write.
  - Reset clears sh_valid to 0. The shadow is not cleared by flush, because the WB write is already committed.
- Hazard detect (combinational): haz = ex_memread && ex_reg != 0 && (there exists i with id_src_used[i] && id_src_reg[i] == ex_reg).
- FSM states are IDLE and STALL, with a down-counter rem of 4 bits.
  - IDLE: stall = haz. If haz && LOAD_STALL > 1, go to STALL with rem = LOAD_STALL-1. Otherwise stay in IDLE.
  - STALL: stall = 1. Decrement rem; when rem == 1, return to IDLE on the next edge. haz is ignored while in STALL.
  - flush = 1 in any state: stall = 0 in that cycle; next state IDLE, rem = 0. flush overrides haz.
  - Each hazard therefore produces exactly LOAD_STALL consecutive stall cycles, starting in the detection cycle.
- stall_count increments on every clock edge where stall = 1 and reset = 0. It holds at all-ones (2^CNT_W - 1) once reached.
- Reset values and reset behaviour:
  - FSM = IDLE, rem = 0, sh_valid = 0, stall_count = 0.
  - stall is forced to 0 while reset = 1.
  - fwd_data/fwd_sel remain combinational. With sh_valid = 0 they reflect only the live inputs.
  - Reset asserted mid-stall returns the FSM to IDLE on the next edge.

Decomposition:
- Shared package pipe_pkg holds:
  - Selector constants FWD_RF = 0, FWD_MEM = 1, FWD_WB = 2, FWD_SH = 3.
  - FSM state encoding HZ_IDLE / HZ_STALL.
  - Default REG_W / DATA_W.
- Sub-module fwd_mux: one instance per port via a generate loop. It is combinational and implements the priority chain above, including the register-0 rule.
- The shadow register, FSM and counter stay in the top module.

Test Plan:
- Priority: ex_src_reg[0] = 5; mem_reg = 5, mem_data = 0xAAAA0001, mem_regwr = 1; wb_reg = 5, wb_data = 0xBBBB0002, wb_regwr = 1 -> fwd_data[0] = 0xAAAA0001, fwd_sel = 1. Then drop mem_regwr -> 0xBBBB0002, sel 2.
- Register zero: ex_src_reg[1] = 0, mem_reg = 0, mem_regwr = 1, ex_src_data[1] = 0 -> fwd_data[1] = 0, sel 0. Shadow is not loaded (sh_valid stays 0).
- Shadow: WB writes r7 = 0x12345678 in cycle n; in cycle n+1, ex_src_reg[0] = 7, ex_src_data = 0xDEAD, no MEM/WB match -> 0x12345678, sel 3. In cycle n+2 -> 0xDEAD, sel 0.
- Load-use, LOAD_STALL = 1: ex_memread = 1, ex_reg = 3, id_src_reg[1] = 3, id_src_used[1] = 1 -> stall = 1 for exactly 1 cycle; stall_count becomes 1. The same case with id_src_used[1] = 0 -> no stall.
- Load-use, LOAD_STALL = 3 with flush: hazard -> stall high for 3 consecutive cycles, stall_count = 3. Repeat and assert flush in the 2nd stall cycle -> stall = 0 in that cycle, FSM in IDLE, stall_count = 4.
- Reset/saturation: with CNT_W = 4, hold the hazard to accumulate 20 stall cycles -> stall_count = 15. Then assert reset mid-STALL -> after one edge stall_count = 0, stall = 0, sh_valid = 0.
